// File: rtl/input_debouncer_if.sv
// Bundles the debouncer's per-bit input and output vectors.
// The testbench or top level drives raw_in; the debouncer drives the rest.
interface input_debouncer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    modport master (output raw_in, input level_out, rise_pulse, fall_pulse);
    modport slave  (input raw_in, output level_out, rise_pulse, fall_pulse);
endinterface

// File: rtl/input_debouncer.sv
// Per-bit debouncer for board push-buttons and switches.
// Each bit has a 2-flop synchronizer, a stability counter, a debounced level and rise/fall pulses.
module input_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input_debouncer_if.slave  bus
);
    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] logical_in;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    cnt_t             cnt_q [WIDTH];
    cnt_t             cnt_d [WIDTH];

    // Invert before synchronizing so everything downstream is active-high.
    assign logical_in = (ACTIVE_LOW != 0) ? ~bus.raw_in : bus.raw_in;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch.
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            // NOTE: the counters are a handful of flops, not a RAM, so they can and must be reset.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep s2_q sampling the old s1_q.
            s1_q    <= logical_in;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.level_out  = level_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: an active-low 4-bit instance and an active-high 10-bit instance.
// A history-window reference model predicts the level and pulses at every edge.
module tb_input_debouncer;
    localparam int S = 4;
    localparam int H = S + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    input_debouncer_if #(.WIDTH(4))  if4 ();
    input_debouncer_if #(.WIDTH(10)) if10 ();

    input_debouncer #(.WIDTH(4), .STABLE_CYCLES(S), .ACTIVE_LOW(1)) dut4 (
        .clk(clk), .reset(reset), .bus(if4)
    );
    input_debouncer #(.WIDTH(10), .STABLE_CYCLES(S), .ACTIVE_LOW(0)) dut10 (
        .clk(clk), .reset(reset), .bus(if10)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // hist[d][k] holds the logical input that was present k edges ago (k=0 is the current edge).
    logic [9:0] hist   [2][H];
    logic [9:0] m_lvl  [2];
    logic [9:0] m_rise [2];
    logic [9:0] m_fall [2];

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < H; k++) hist[d][k] = '0;
            m_lvl[d]  = '0;
            m_rise[d] = '0;
            m_fall[d] = '0;
        end
    endtask

    // A bit flips when the synchronized input has disagreed with the level for S consecutive edges.
    // The synchronized input seen at this edge is the raw input from two edges back.
    task automatic model_edge();
        logic [9:0] inp [2];
        logic       differs;
        inp[0] = {6'b0, ~if4.raw_in};
        inp[1] = if10.raw_in;
        for (int d = 0; d < 2; d++) begin
            for (int k = H - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = inp[d];
            m_rise[d]  = '0;
            m_fall[d]  = '0;
            for (int i = 0; i < 10; i++) begin
                differs = 1'b1;
                for (int j = 0; j < S; j++)
                    if (hist[d][2+j][i] == m_lvl[d][i]) differs = 1'b0;
                if (differs) begin
                    m_lvl[d][i]  = ~m_lvl[d][i];
                    m_rise[d][i] = m_lvl[d][i];
                    m_fall[d][i] = ~m_lvl[d][i];
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("lvl4",  {6'b0, if4.level_out},  m_lvl[0]);
        chk("rise4", {6'b0, if4.rise_pulse}, m_rise[0]);
        chk("fall4", {6'b0, if4.fall_pulse}, m_fall[0]);
        chk("lvl10",  if10.level_out,  m_lvl[1]);
        chk("rise10", if10.rise_pulse, m_rise[1]);
        chk("fall10", if10.fall_pulse, m_fall[1]);
    endtask

    // One clock edge: advance the model, then sample 1 time unit after the edge.
    task automatic edge_step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        compare_all();
    endtask

    int hold4  [4];
    int hold10 [10];

    initial begin
        reset       = 1'b1;
        if4.raw_in  = 4'hF;
        if10.raw_in = '0;
        model_clear();
        #1;
        chk("rst_lvl4",  {6'b0, if4.level_out},  10'h0);
        chk("rst_rise4", {6'b0, if4.rise_pulse}, 10'h0);
        repeat (3) edge_step();
        reset = 1'b0;

        // Idle with all keys released: nothing moves.
        repeat (20) edge_step();
        chk("idle_lvl4", {6'b0, if4.level_out}, 10'h0);

        // Press bit 0: level rises exactly on the sixth edge.
        if4.raw_in = 4'b1110;
        repeat (5) edge_step();
        chk("press0_e5_lvl", {6'b0, if4.level_out}, 10'h0);
        edge_step();
        chk("press0_e6_lvl",  {6'b0, if4.level_out},  10'h1);
        chk("press0_e6_rise", {6'b0, if4.rise_pulse}, 10'h1);
        edge_step();
        chk("press0_e7_rise", {6'b0, if4.rise_pulse}, 10'h0);
        repeat (3) edge_step();

        // Release bit 0: single fall pulse on the sixth edge.
        if4.raw_in = 4'hF;
        repeat (5) edge_step();
        edge_step();
        chk("rel0_e6_fall", {6'b0, if4.fall_pulse}, 10'h1);
        chk("rel0_e6_lvl",  {6'b0, if4.level_out},  10'h0);
        chk("rel0_e6_rise", {6'b0, if4.rise_pulse}, 10'h0);
        repeat (4) edge_step();

        // Glitch on bit 1 too short to register, then a real press.
        if4.raw_in = 4'b1101;
        repeat (3) edge_step();
        if4.raw_in = 4'hF;
        repeat (10) edge_step();
        chk("glitch1_lvl", {6'b0, if4.level_out}, 10'h0);
        if4.raw_in = 4'b1101;
        repeat (5) edge_step();
        edge_step();
        chk("press1_rise", {6'b0, if4.rise_pulse}, 10'h2);
        if4.raw_in = 4'hF;
        repeat (8) edge_step();

        // Bits 2 and 3 together on the 4-bit part, pattern 2A5 on the 10-bit part.
        if4.raw_in  = 4'b0011;
        if10.raw_in = 10'h2A5;
        repeat (5) edge_step();
        edge_step();
        chk("press23_rise",  {6'b0, if4.rise_pulse}, 10'h00C);
        chk("sw_lvl",  if10.level_out,  10'h2A5);
        chk("sw_rise", if10.rise_pulse, 10'h2A5);
        edge_step();
        chk("sw_rise_end", if10.rise_pulse, 10'h000);

        // Release bits 2 and 3, then reset while the release is still counting.
        if4.raw_in = 4'hF;
        repeat (3) edge_step();
        reset = 1'b1;
        #1;
        model_clear();
        chk("async_lvl4",   {6'b0, if4.level_out},  10'h0);
        chk("async_lvl10",  if10.level_out,         10'h0);
        chk("async_rise4",  {6'b0, if4.rise_pulse}, 10'h0);
        repeat (3) edge_step();
        reset = 1'b0;
        repeat (10) edge_step();
        chk("post_rst_fall4", {6'b0, if4.fall_pulse}, 10'h0);
        chk("post_rst_lvl4",  {6'b0, if4.level_out},  10'h0);

        // Random bounce: each bit toggles after a random hold of 1..7 cycles.
        for (int i = 0; i < 4; i++)  hold4[i]  = int'($urandom_range(1, 7));
        for (int i = 0; i < 10; i++) hold10[i] = int'($urandom_range(1, 7));
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                hold4[i]--;
                if (hold4[i] == 0) begin
                    if4.raw_in[i] = ~if4.raw_in[i];
                    hold4[i] = int'($urandom_range(1, 7));
                end
            end
            for (int i = 0; i < 10; i++) begin
                hold10[i]--;
                if (hold10[i] == 0) begin
                    if10.raw_in[i] = ~if10.raw_in[i];
                    hold10[i] = int'($urandom_range(1, 7));
                end
            end
            if (n == 300) begin
                reset = 1'b1;
                #1;
                model_clear();
                chk("rand_async_lvl10", if10.level_out, 10'h0);
            end
            if (n == 303) reset = 1'b0;
            edge_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
